// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 exception/interrupt controller.
//  - register addresses (STATUS, CAUSE, EPC, PENDING)
//  - STATUS / CAUSE bit positions and reset value
//  - exception cause codes and the FSM state type
package cp0_pkg;

    localparam logic [31:0] ADDR_STATUS  = 32'h0000_0060;
    localparam logic [31:0] ADDR_CAUSE   = 32'h0000_0068;
    localparam logic [31:0] ADDR_EPC     = 32'h0000_0070;
    localparam logic [31:0] ADDR_PENDING = 32'h0000_0078;

    localparam int STATUS_GIE      = 31;
    localparam int STATUS_OVF_EN   = 0;
    localparam int STATUS_INV_EN   = 1;
    localparam int STATUS_MASK_LSB = 8;
    localparam logic [31:0] STATUS_RESET = 32'h8000_0003;

    localparam int CAUSE_CODE_LSB = 2;
    localparam int CAUSE_PEND_LSB = 8;

    localparam logic [4:0] CODE_NONE     = 5'd0;
    localparam logic [4:0] CODE_OVF      = 5'd1;
    localparam logic [4:0] CODE_INV      = 5'd2;
    localparam logic [4:0] CODE_IRQ_BASE = 5'd8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HANDLER = 1'b1
    } cp0_state_t;

    // Cause code for external line idx (8 + idx).
    function automatic logic [4:0] irq_code(input logic [3:0] idx);
        return CODE_IRQ_BASE + {1'b0, idx};
    endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// cp0_prio_enc: fixed-priority encoder, lowest set index wins.
//  i_req   N   request vector
//  o_valid 1   any request set
//  o_idx   IW  index of the lowest set request (0 when none)
module cp0_prio_enc #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) o_idx = IW'(k);
        end
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: coprocessor-0 exception/interrupt controller for the MIPS32 core.
// Per-line pending latches (level or rising-edge), fixed-priority arbitration
// (overflow > invalid > lowest unmasked irq), vectored handler addresses and a
// two-state IDLE/HANDLER FSM that blocks nesting until ERET.
//  i_clk / i_rst          clock, synchronous active-high reset
//  i_we/i_addr/i_data     register write port
//  i_pc                   word PC of the current instruction (captured to EPC on take)
//  i_overflow/i_invalid_instr  synchronous exceptions
//  i_irq                  external interrupt lines
//  i_eret                 return from handler
//  o_data                 register read data, combinational on i_addr
//  o_return_addr          EPC
//  o_instr_addr           handler vector while o_interrupt, else 0
//  o_interrupt            exception taken this cycle
//  o_in_handler           handler active
module cp0_irq_ctrl
    import cp0_pkg::*;
#(
    parameter int                 NUM_IRQ       = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE      = '0,
    parameter logic [29:0]        VECTOR_BASE   = 30'h002,
    parameter int                 VECTOR_STRIDE = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_data,
    input  logic [29:0]        i_pc,
    input  logic               i_overflow,
    input  logic               i_invalid_instr,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_eret,
    output logic [31:0]        o_data,
    output logic [29:0]        o_return_addr,
    output logic [29:0]        o_instr_addr,
    output logic               o_interrupt,
    output logic               o_in_handler
);

    cp0_state_t state, state_nxt;

    logic               gie, ovf_en, inv_en;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend;
    logic [4:0]         cause_code;
    logic [29:0]        epc;

    logic wr_status, wr_cause, wr_epc, wr_pending;
    assign wr_status  = i_we && (i_addr == ADDR_STATUS);
    assign wr_cause   = i_we && (i_addr == ADDR_CAUSE);
    assign wr_epc     = i_we && (i_addr == ADDR_EPC);
    assign wr_pending = i_we && (i_addr == ADDR_PENDING);

    // Per-line pending. Edge lines latch a rising edge until software clears
    // it (a new edge beats a same-cycle clear); level lines just follow the
    // registered input and ignore clears.
    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_line
        if (IRQ_EDGE[k]) begin : g_edge
            logic pend_q;
            always_ff @(posedge i_clk) begin
                if (i_rst)                         pend_q <= 1'b0;
                else if (i_irq[k] && !irq_q[k])    pend_q <= 1'b1;
                else if (wr_pending && i_data[k])  pend_q <= 1'b0;
            end
            assign pend[k] = pend_q;
        end else begin : g_level
            assign pend[k] = irq_q[k];
        end
    end

    // Arbitration
    logic       irq_valid;
    logic [3:0] irq_idx;
    logic       take;
    logic [4:0] take_code;
    logic [29:0] vector;

    cp0_prio_enc #(.N(NUM_IRQ), .IW(4)) u_prio (
        .i_req   (pend & mask),
        .o_valid (irq_valid),
        .o_idx   (irq_idx)
    );

    always_comb begin
        take_code = CODE_NONE;
        if (ovf_en && i_overflow)           take_code = CODE_OVF;
        else if (inv_en && i_invalid_instr) take_code = CODE_INV;
        else if (irq_valid)                 take_code = irq_code(irq_idx);
    end

    // take_code is non-zero exactly when some enabled request is present.
    assign take   = gie && (state == ST_IDLE) && (take_code != CODE_NONE);
    assign vector = VECTOR_BASE + 30'(take_code) * 30'(VECTOR_STRIDE);

    assign o_interrupt   = take;
    assign o_instr_addr  = take ? vector : '0;
    assign o_in_handler  = (state == ST_HANDLER);
    assign o_return_addr = epc;

    // FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (take)   state_nxt = ST_HANDLER;
            ST_HANDLER: if (i_eret) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Registers. Taking an exception overrides software writes to EPC/CAUSE;
    // STATUS writes always land (take already used the old values).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gie        <= STATUS_RESET[STATUS_GIE];
            ovf_en     <= STATUS_RESET[STATUS_OVF_EN];
            inv_en     <= STATUS_RESET[STATUS_INV_EN];
            mask       <= '0;
            cause_code <= '0;
            epc        <= '0;
            irq_q      <= '0;
        end else begin
            irq_q <= i_irq;
            if (wr_status) begin
                gie    <= i_data[STATUS_GIE];
                ovf_en <= i_data[STATUS_OVF_EN];
                inv_en <= i_data[STATUS_INV_EN];
                mask   <= i_data[STATUS_MASK_LSB +: NUM_IRQ];
            end
            if (take) begin
                epc        <= i_pc;
                cause_code <= take_code;
            end else begin
                if (wr_epc)   epc        <= i_data[31:2];
                if (wr_cause) cause_code <= i_data[CAUSE_CODE_LSB +: 5];
            end
        end
    end

    // Read mux
    logic [31:0] status_rd, cause_rd;

    always_comb begin
        status_rd = '0;
        status_rd[STATUS_GIE]                = gie;
        status_rd[STATUS_OVF_EN]             = ovf_en;
        status_rd[STATUS_INV_EN]             = inv_en;
        status_rd[STATUS_MASK_LSB +: NUM_IRQ] = mask;
        cause_rd = '0;
        cause_rd[CAUSE_CODE_LSB +: 5]        = cause_code;
        cause_rd[CAUSE_PEND_LSB +: NUM_IRQ]  = pend;
    end

    always_comb begin
        case (i_addr)
            ADDR_STATUS:  o_data = status_rd;
            ADDR_CAUSE:   o_data = cause_rd;
            ADDR_EPC:     o_data = {epc, 2'b00};
            ADDR_PENDING: o_data = {{(32-NUM_IRQ){1'b0}}, pend};
            default:      o_data = '0;
        endcase
    end

endmodule
